// File: rtl/cnn_window_ctrl_if.sv
// -----------------------------------------------------------------------------
// cnn_window_ctrl_if
// Handshake and window-report bundle between the pixel source / MAC array
// (master side) and the window sequencer cnn_window_ctrl (slave side).
//
// Signals:
//   start      master->slave  one-cycle pulse arming a new frame
//   in_valid   master->slave  upstream pixel valid
//   in_ready   slave->master  sequencer can accept a pixel
//   shift_en   slave->master  line-buffer shift enable (in_valid & in_ready)
//   win_valid  slave->master  window at the taps is legal this cycle
//   win_row    slave->master  output-map row of the current window
//   win_col    slave->master  output-map column of the current window
//   frame_done slave->master  pulse with the last window of the frame
//   busy       slave->master  sequencer is not idle
// -----------------------------------------------------------------------------
interface cnn_window_ctrl_if #(
  parameter int CW = 6
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          shift_en;
  logic          win_valid;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_done;
  logic          busy;

  modport master (
    output start,
    output in_valid,
    input  in_ready,
    input  shift_en,
    input  win_valid,
    input  win_row,
    input  win_col,
    input  frame_done,
    input  busy
  );

  modport slave (
    input  start,
    input  in_valid,
    output in_ready,
    output shift_en,
    output win_valid,
    output win_row,
    output win_col,
    output frame_done,
    output busy
  );
endinterface

// File: rtl/cnn_window_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_window_ctrl
// Sequencer for the KxK convolution window generator. Accepts a raster-order
// pixel stream, drives the line-buffer shift enable, tracks the row/column of
// each accepted pixel and flags (after WIN_LAT cycles, when the window has
// reached the tap registers) the cycles in which the window is a legal
// convolution window, together with its output-map coordinates. frame_done
// pulses with the last window of the frame.
//
// Optional build macro: STRIDE2_EN
//   defined   -> only windows at even offsets are legal, coordinates report
//                the stride-2 output index.
//   undefined -> stride 1.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-high reset
//   bus   slave modport of cnn_window_ctrl_if (start, in_valid, in_ready,
//         shift_en, win_valid, win_row, win_col, frame_done, busy)
//
// Parameters: IMG_W, IMG_H (>= K), K, WIN_LAT (>= 1), CW (2^CW > max(W,H)).
// -----------------------------------------------------------------------------
module cnn_window_ctrl #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int K       = 5,
  parameter int WIN_LAT = 1,
  parameter int CW      = 6
) (
  input  logic                clk,
  input  logic                rst,
  cnn_window_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LP_COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LP_ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] LP_KM1      = CW'(K - 1);
`ifdef STRIDE2_EN
  localparam logic [CW-1:0] LP_ROW_FIN  = CW'((IMG_H - K) / 2);
  localparam logic [CW-1:0] LP_COL_FIN  = CW'((IMG_W - K) / 2);
`else
  localparam logic [CW-1:0] LP_ROW_FIN  = CW'(IMG_H - K);
  localparam logic [CW-1:0] LP_COL_FIN  = CW'(IMG_W - K);
`endif
  localparam int DCW = (WIN_LAT > 1) ? $clog2(WIN_LAT) : 1;
  localparam logic [DCW-1:0] LP_DRAIN_INIT = DCW'(WIN_LAT - 1);

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_row;
  logic [CW-1:0]  r_col;
  logic [DCW-1:0] r_drain_cnt;

  logic           w_in_ready;
  logic           w_busy;
  logic           w_accept;
  logic           w_last_pix;
  logic           w_legal;
  logic [CW-1:0]  w_row_off;
  logic [CW-1:0]  w_col_off;
  logic [CW-1:0]  w_row_idx;
  logic [CW-1:0]  w_col_idx;

  // Window delay pipe: entry 0 is loaded on the accept edge, entry
  // WIN_LAT-1 lines up with the window at the tap registers.
  logic           r_vld_p [WIN_LAT];
  logic [CW-1:0]  r_row_p [WIN_LAT];
  logic [CW-1:0]  r_col_p [WIN_LAT];

  logic           w_win_valid;
  logic [CW-1:0]  w_win_row;
  logic [CW-1:0]  w_win_col;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_accept && w_last_pix) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last window leaves the pipe in the final DRAIN cycle.
        if (r_drain_cnt == '0) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      S_STREAM: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      S_DRAIN: begin
        w_busy     = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
      end
    endcase
  end

  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_last_pix = (r_row == LP_ROW_LAST) && (r_col == LP_COL_LAST);

  // ---------------------------------------------------------------------------
  // Drain counter: counts down the WIN_LAT cycles spent in DRAIN
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if ((r_state == S_STREAM) && w_accept && w_last_pix) begin
      r_drain_cnt <= LP_DRAIN_INIT;
    end else if ((r_state == S_DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - DCW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Raster position of the next pixel to be accepted
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (r_col == LP_COL_LAST) begin
        r_col <= '0;
        // Last pixel returns the row to 0 so counters stay in range.
        r_row <= (r_row == LP_ROW_LAST) ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Legality and output coordinates from the pre-increment counters.
  assign w_row_off = r_row - LP_KM1;
  assign w_col_off = r_col - LP_KM1;

`ifdef STRIDE2_EN
  assign w_legal   = (r_row >= LP_KM1) && (r_col >= LP_KM1) &&
                     !w_row_off[0] && !w_col_off[0];
  assign w_row_idx = {1'b0, w_row_off[CW-1:1]};
  assign w_col_idx = {1'b0, w_col_off[CW-1:1]};
`else
  assign w_legal   = (r_row >= LP_KM1) && (r_col >= LP_KM1);
  assign w_row_idx = w_row_off;
  assign w_col_idx = w_col_off;
`endif

  // ---------------------------------------------------------------------------
  // Window pipe stages _p0 .. _p(WIN_LAT-1)
  // ---------------------------------------------------------------------------
  // Coordinates only advance behind a valid entry, so the last stage keeps the
  // coordinates of the most recent legal window through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN_LAT; i++) begin
        r_vld_p[i] <= 1'b0;
        r_row_p[i] <= '0;
        r_col_p[i] <= '0;
      end
    end else begin
      r_vld_p[0] <= w_accept & w_legal;
      if (w_accept && w_legal) begin
        r_row_p[0] <= w_row_idx;
        r_col_p[0] <= w_col_idx;
      end
      for (int i = 1; i < WIN_LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        if (r_vld_p[i-1]) begin
          r_row_p[i] <= r_row_p[i-1];
          r_col_p[i] <= r_col_p[i-1];
        end
      end
    end
  end

  assign w_win_valid = r_vld_p[WIN_LAT-1];
  assign w_win_row   = r_row_p[WIN_LAT-1];
  assign w_win_col   = r_col_p[WIN_LAT-1];

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.in_ready   = w_in_ready;
  assign bus.shift_en   = w_accept;
  assign bus.busy       = w_busy;
  assign bus.win_valid  = w_win_valid;
  assign bus.win_row    = w_win_row;
  assign bus.win_col    = w_win_col;
  // Window coordinates are unique within a frame, so matching the final one
  // identifies the last window.
  assign bus.frame_done = w_win_valid && (w_win_row == LP_ROW_FIN) &&
                          (w_win_col == LP_COL_FIN);

endmodule

// File: tb/tb_cnn_window_ctrl.sv
module tb_cnn_window_ctrl;

  localparam int CW   = 6;
  localparam int AW   = 8;
  localparam int AH   = 6;
  localparam int AK   = 5;
  localparam int ALAT = 1;
  localparam int BW   = 5;
  localparam int BH   = 5;
  localparam int BK   = 5;
  localparam int BLAT = 4;
`ifdef STRIDE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_window_ctrl_if #(.CW(CW)) ifa ();
  cnn_window_ctrl_if #(.CW(CW)) ifb ();

  cnn_window_ctrl #(.IMG_W(AW), .IMG_H(AH), .K(AK), .WIN_LAT(ALAT), .CW(CW)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  cnn_window_ctrl #(.IMG_W(BW), .IMG_H(BH), .K(BK), .WIN_LAT(BLAT), .CW(CW)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int tests = 0;
  int fails = 0;

  // Scheduled window events for DUT A, indexed by cycle within a frame.
  bit ev_v [4096];
  bit ev_l [4096];
  int ev_r [4096];
  int ev_c [4096];
  logic [CW-1:0] exp_row_a = '0;
  logic [CW-1:0] exp_col_a = '0;

  task automatic test_reset();
    rst = 1'b1;
    ifa.start = 1'b0; ifa.in_valid = 1'b0;
    ifb.start = 1'b0; ifb.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++; if (ifa.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", ifa.in_ready); end
    tests++; if (ifa.shift_en !== 1'b0) begin fails++; $display("FAIL reset_shift_en got %b want 0", ifa.shift_en); end
    tests++; if (ifa.win_valid !== 1'b0) begin fails++; $display("FAIL reset_win_valid got %b want 0", ifa.win_valid); end
    tests++; if (ifa.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", ifa.frame_done); end
    tests++; if (ifa.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", ifa.busy); end
    tests++; if (ifa.win_row !== '0 || ifa.win_col !== '0) begin fails++; $display("FAIL reset_coords got (%0d,%0d) want (0,0)", ifa.win_row, ifa.win_col); end
    tests++; if (ifb.busy !== 1'b0 || ifb.win_valid !== 1'b0) begin fails++; $display("FAIL reset_b got busy=%b win_valid=%b want 0,0", ifb.busy, ifb.win_valid); end
    @(posedge clk); #1;
    tests++; if (ifa.busy !== 1'b0) begin fails++; $display("FAIL idle_hold_busy got %b want 0", ifa.busy); end
  endtask

  // Runs one frame on DUT A against a raster-order model.
  // mode: 0 = in_valid always 1, 1 = toggling, 2 = random.
  task automatic test_frame(input int mode, input int abort_after, input bit start_mid,
                            input bit start_at_done, input string name);
    int cyc;
    int n;
    int t_last;
    int pulses;
    int exp_pulses;
    int pr;
    int pc;
    bit vin;
    bit exp_ready;
    bit exp_busy;
    bit exp_fd;
    for (int i = 0; i < 4096; i++) begin
      ev_v[i] = 1'b0; ev_l[i] = 1'b0;
    end
    exp_pulses = ((AH - AK) / S + 1) * ((AW - AK) / S + 1);
    pulses = 0; n = 0; t_last = -100;
    @(posedge clk); #1;
    ifa.start = 1'b1; ifa.in_valid = 1'b0;
    #1;
    tests++; if (ifa.busy !== 1'b0 || ifa.in_ready !== 1'b0) begin fails++; $display("FAIL %s_idle got busy=%b in_ready=%b want 0,0", name, ifa.busy, ifa.in_ready); end
    @(posedge clk); #1;
    cyc = 1;
    while (1) begin
      case (mode)
        0:       vin = 1'b1;
        1:       vin = (cyc % 2) == 1;
        default: vin = $urandom_range(0, 99) < 60;
      endcase
      ifa.in_valid = vin;
      ifa.start = (start_mid && cyc == 10) || (start_at_done && ev_l[cyc]);
      #1;
      exp_ready = (n < AW * AH);
      exp_busy  = exp_ready || (cyc <= t_last + ALAT);
      exp_fd    = ev_v[cyc] && ev_l[cyc];
      if (ev_v[cyc]) begin
        pulses++;
        exp_row_a = CW'(ev_r[cyc]);
        exp_col_a = CW'(ev_c[cyc]);
      end
      tests++; if (ifa.in_ready !== exp_ready) begin fails++; $display("FAIL %s_in_ready cyc %0d got %b want %b", name, cyc, ifa.in_ready, exp_ready); end
      tests++; if (ifa.shift_en !== (exp_ready & vin)) begin fails++; $display("FAIL %s_shift_en cyc %0d got %b want %b", name, cyc, ifa.shift_en, exp_ready & vin); end
      tests++; if (ifa.busy !== exp_busy) begin fails++; $display("FAIL %s_busy cyc %0d got %b want %b", name, cyc, ifa.busy, exp_busy); end
      tests++; if (ifa.win_valid !== ev_v[cyc]) begin fails++; $display("FAIL %s_win_valid cyc %0d got %b want %b", name, cyc, ifa.win_valid, ev_v[cyc]); end
      tests++; if (ifa.frame_done !== exp_fd) begin fails++; $display("FAIL %s_frame_done cyc %0d got %b want %b", name, cyc, ifa.frame_done, exp_fd); end
      tests++; if (ifa.win_row !== exp_row_a || ifa.win_col !== exp_col_a) begin fails++; $display("FAIL %s_coords cyc %0d got (%0d,%0d) want (%0d,%0d)", name, cyc, ifa.win_row, ifa.win_col, exp_row_a, exp_col_a); end
      if (exp_ready && vin) begin
        pr = n / AW;
        pc = n % AW;
        if (pr >= AK - 1 && pc >= AK - 1 && ((pr - (AK - 1)) % S) == 0 && ((pc - (AK - 1)) % S) == 0) begin
          ev_v[cyc + ALAT] = 1'b1;
          ev_r[cyc + ALAT] = (pr - (AK - 1)) / S;
          ev_c[cyc + ALAT] = (pc - (AK - 1)) / S;
          ev_l[cyc + ALAT] = (ev_r[cyc + ALAT] == (AH - AK) / S) && (ev_c[cyc + ALAT] == (AW - AK) / S);
        end
        n++;
        if (n == AW * AH) t_last = cyc;
        if (abort_after > 0 && n == abort_after) begin
          @(posedge clk); #1;
          rst = 1'b1; ifa.in_valid = 1'b0; ifa.start = 1'b0;
          @(posedge clk); #1;
          rst = 1'b0;
          exp_row_a = '0; exp_col_a = '0;
          for (int k = 0; k < 4; k++) begin
            #1;
            tests++; if (ifa.busy !== 1'b0 || ifa.in_ready !== 1'b0 || ifa.shift_en !== 1'b0) begin fails++; $display("FAIL %s_abort_ctrl k %0d got busy=%b rdy=%b sh=%b want 0,0,0", name, k, ifa.busy, ifa.in_ready, ifa.shift_en); end
            tests++; if (ifa.win_valid !== 1'b0 || ifa.frame_done !== 1'b0) begin fails++; $display("FAIL %s_abort_win k %0d got wv=%b fd=%b want 0,0", name, k, ifa.win_valid, ifa.frame_done); end
            tests++; if (ifa.win_row !== '0 || ifa.win_col !== '0) begin fails++; $display("FAIL %s_abort_coords got (%0d,%0d) want (0,0)", name, ifa.win_row, ifa.win_col); end
            @(posedge clk); #1;
          end
          return;
        end
      end
      if (!exp_ready && cyc == t_last + ALAT + 1) break;
      if (cyc > 3000) begin
        tests++; fails++;
        $display("FAIL %s_timeout got %0d accepts want %0d", name, n, AW * AH);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ifa.in_valid = 1'b0;
    ifa.start = 1'b0;
    tests++; if (pulses != exp_pulses) begin fails++; $display("FAIL %s_pulse_count got %0d want %0d", name, pulses, exp_pulses); end
    tests++; if (exp_row_a !== CW'((AH - AK) / S) || exp_col_a !== CW'((AW - AK) / S)) begin fails++; $display("FAIL %s_last_window got (%0d,%0d) want (%0d,%0d)", name, exp_row_a, exp_col_a, (AH - AK) / S, (AW - AK) / S); end
  endtask

  task automatic test_full_stream();
    test_frame(0, 0, 1'b0, 1'b0, "full");
  endtask

  task automatic test_bubbles();
    test_frame(1, 0, 1'b0, 1'b0, "toggle");
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) test_frame(2, 0, 1'b0, 1'b0, "random");
  endtask

  task automatic test_abort();
    test_frame(0, 30, 1'b0, 1'b0, "abort");
    test_frame(0, 0, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_start_ignored();
    test_frame(0, 0, 1'b1, 1'b1, "start_ign");
    test_frame(2, 0, 1'b0, 1'b0, "restart");
  endtask

  task automatic test_latency4();
    bit exp_win;
    @(posedge clk); #1;
    ifb.start = 1'b1; ifb.in_valid = 1'b1;
    #1;
    tests++; if (ifb.busy !== 1'b0) begin fails++; $display("FAIL lat4_idle_busy got %b want 0", ifb.busy); end
    @(posedge clk); #1;
    ifb.start = 1'b0;
    for (int cyc = 1; cyc <= 31; cyc++) begin
      #1;
      exp_win = (cyc == BW * BH + BLAT);
      tests++; if (ifb.in_ready !== (cyc <= BW * BH)) begin fails++; $display("FAIL lat4_in_ready cyc %0d got %b want %b", cyc, ifb.in_ready, cyc <= BW * BH); end
      tests++; if (ifb.win_valid !== exp_win) begin fails++; $display("FAIL lat4_win_valid cyc %0d got %b want %b", cyc, ifb.win_valid, exp_win); end
      tests++; if (ifb.frame_done !== exp_win) begin fails++; $display("FAIL lat4_frame_done cyc %0d got %b want %b", cyc, ifb.frame_done, exp_win); end
      tests++; if (ifb.busy !== (cyc <= BW * BH + BLAT)) begin fails++; $display("FAIL lat4_busy cyc %0d got %b want %b", cyc, ifb.busy, cyc <= BW * BH + BLAT); end
      tests++; if (ifb.win_row !== '0 || ifb.win_col !== '0) begin fails++; $display("FAIL lat4_coords cyc %0d got (%0d,%0d) want (0,0)", cyc, ifb.win_row, ifb.win_col); end
      @(posedge clk); #1;
    end
    ifb.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_bubbles();
    test_random();
    test_abort();
    test_start_ignored();
    test_latency4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
